// File: rtl/fifo_uart_tx_cfg_if.sv
// Host-side bundle of the FIFO-fronted UART transmitter: write port, runtime
// frame configuration, serial line and FIFO status.
interface fifo_uart_tx_cfg_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned DIV_WIDTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                 i_fifo_enable;
    logic                 i_tx_enable;
    logic                 i_w_en;
    logic [WIDTH-1:0]     i_w_data;
    logic [DIV_WIDTH-1:0] i_divisor;
    logic [1:0]           i_parity_mode;
    logic                 i_two_stop;
    logic                 i_lsb_first;
    logic                 i_clr_ovf;

    logic                 o_tx;
    logic                 o_busy;
    logic                 o_full;
    logic                 o_afull;
    logic                 o_empty;
    logic                 o_aempty;
    logic [CW-1:0]        o_count;
    logic                 o_overflow;

    modport master (
        output i_fifo_enable, i_tx_enable, i_w_en, i_w_data, i_divisor,
               i_parity_mode, i_two_stop, i_lsb_first, i_clr_ovf,
        input  o_tx, o_busy, o_full, o_afull, o_empty, o_aempty, o_count, o_overflow
    );

    modport slave (
        input  i_fifo_enable, i_tx_enable, i_w_en, i_w_data, i_divisor,
               i_parity_mode, i_two_stop, i_lsb_first, i_clr_ovf,
        output o_tx, o_busy, o_full, o_afull, o_empty, o_aempty, o_count, o_overflow
    );
endinterface

// File: rtl/fifo_uart_tx_cfg.sv
// Buffered UART transmitter: write FIFO with registered occupancy flags and
// sticky overflow, feeding a serialiser whose frame format is latched per pop.
module fifo_uart_tx_cfg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned LEVEL     = 16,
    parameter int unsigned DIV_WIDTH = 16
) (
    input logic              clk,
    input logic              i_reset_n,
    fifo_uart_tx_cfg_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // ---------------- FIFO ----------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, afull_q, empty_q, aempty_q;
    logic             ovf_q, ovf_d;
    logic             push_c, pop_c, ovf_hit_c;
    logic [WIDTH-1:0] head_c;

    // Full is the registered flag, so a write while full is dropped even if a pop frees a slot.
    assign push_c    = bus.i_w_en & bus.i_fifo_enable & ~full_q;
    assign ovf_hit_c = bus.i_w_en & bus.i_fifo_enable & full_q;
    assign head_c    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q + CW'(push_c) - CW'(pop_c);
        ovf_d   = ovf_q;
        if (bus.i_clr_ovf) ovf_d = 1'b0;
        if (ovf_hit_c)     ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= bus.i_w_data;
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            afull_q  <= (count_d >= CW'(DEPTH - LEVEL));
            empty_q  <= (count_d == '0);
            aempty_q <= (count_d <= CW'(LEVEL));
            ovf_q    <= ovf_d;
        end
    end

    // ---------------- serialiser ----------------
    state_e               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] timer_q, timer_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 two_stop_q, two_stop_d;
    logic                 lsb_q, lsb_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_done_c, can_pop_c, load_c;

    assign bit_done_c = (timer_q == div_q - DIV_WIDTH'(1));
    assign can_pop_c  = bus.i_tx_enable & ~empty_q;

    function automatic logic bit_at(input logic [WIDTH-1:0] d, input logic [BW-1:0] i,
                                    input logic lsb);
        logic [BW-1:0] j;
        j = lsb ? i : (BW'(WIDTH - 1) - i);
        return d[j];
    endfunction

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        div_d      = div_q;
        idx_d      = idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        lsb_d      = lsb_q;
        stop_d     = stop_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        timer_d    = bit_done_c ? '0 : timer_q + DIV_WIDTH'(1);
        load_c     = 1'b0;
        pop_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (can_pop_c) load_c = 1'b1;
            end
            S_START: begin
                if (bit_done_c) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = bit_at(data_q, '0, lsb_q);
                end
            end
            S_DATA: begin
                if (bit_done_c) begin
                    if (idx_q == BW'(WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + BW'(1);
                        tx_d  = bit_at(data_q, idx_q + BW'(1), lsb_q);
                    end
                end
            end
            S_PARITY: begin
                if (bit_done_c) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_done_c) begin
                    // Last stop period: chain the next frame with no idle gap when possible.
                    if (stop_q == two_stop_q) begin
                        if (can_pop_c) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Pop the head word and freeze the frame format for the whole frame.
        if (load_c) begin
            pop_c      = 1'b1;
            state_d    = S_START;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            timer_d    = '0;
            data_d     = head_c;
            div_d      = (bus.i_divisor == '0) ? DIV_WIDTH'(1) : bus.i_divisor;
            par_en_d   = (bus.i_parity_mode == 2'b01) || (bus.i_parity_mode == 2'b10);
            par_bit_d  = (bus.i_parity_mode == 2'b10) ? ~(^head_c) : (^head_c);
            two_stop_d = bus.i_two_stop;
            lsb_d      = bus.i_lsb_first;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            div_q      <= DIV_WIDTH'(1);
            timer_q    <= '0;
            idx_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            lsb_q      <= 1'b1;
            stop_q     <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            div_q      <= div_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            lsb_q      <= lsb_d;
            stop_q     <= stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_tx       = tx_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_full     = full_q;
    assign bus.o_afull    = afull_q;
    assign bus.o_empty    = empty_q;
    assign bus.o_aempty   = aempty_q;
    assign bus.o_count    = count_q;
    assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_fifo_uart_tx_cfg.sv
// Bench for fifo_uart_tx_cfg: per-clock serial waveforms and FIFO flags are
// compared against a frame-symbol model and a queue model of the FIFO.
module tb_fifo_uart_tx_cfg;
    localparam int unsigned W   = 8;
    localparam int unsigned D   = 8;
    localparam int unsigned LVL = 2;
    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = $clog2(D) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_uart_tx_cfg_if #(.WIDTH(W), .DEPTH(D), .DIV_WIDTH(DW)) bus ();

    fifo_uart_tx_cfg #(.WIDTH(W), .DEPTH(D), .LEVEL(LVL), .DIV_WIDTH(DW)) dut (
        .clk      (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] model_q[$];
    logic [127:0] exp_tx, exp_busy, cap_tx, cap_busy;
    int           exp_len;

    // Expected line level per clock: symbols (start, data, parity, stops) each held div clocks.
    function automatic void build_frame(input logic [W-1:0] d, input int div, input logic [1:0] mode,
                                        input logic two, input logic lsb);
        logic syms[$];
        int de;
        de = (div == 0) ? 1 : div;
        syms.push_back(1'b0);
        for (int k = 0; k < int'(W); k++) syms.push_back(lsb ? d[k] : d[int'(W) - 1 - k]);
        if (mode == 2'b01) syms.push_back(^d);
        if (mode == 2'b10) syms.push_back(~(^d));
        syms.push_back(1'b1);
        if (two) syms.push_back(1'b1);
        exp_tx  = '0;
        exp_len = 0;
        foreach (syms[s]) begin
            for (int r = 0; r < de; r++) begin
                exp_tx[exp_len] = syms[s];
                exp_len++;
            end
        end
        exp_busy = (128'(1) << exp_len) - 128'(1);
    endfunction

    // Record tx/busy for n clocks; at cycle chg_at, disturb the config and drop tx_enable.
    task automatic capture(input int n, input int chg_at);
        cap_tx   = '0;
        cap_busy = '0;
        for (int i = 0; i < n; i++) begin
            cap_tx[i]   = bus.o_tx;
            cap_busy[i] = bus.o_busy;
            if (i == chg_at) begin
                bus.i_tx_enable   = 1'b0;
                bus.i_divisor     = DW'(7);
                bus.i_parity_mode = 2'b10;
                bus.i_two_stop    = 1'b1;
                bus.i_lsb_first   = ~bus.i_lsb_first;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_start(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.o_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic set_cfg(input int div, input logic [1:0] mode, input logic two, input logic lsb);
        bus.i_divisor     = DW'(div);
        bus.i_parity_mode = mode;
        bus.i_two_stop    = two;
        bus.i_lsb_first   = lsb;
    endtask

    task automatic write_word(input logic [W-1:0] d, input logic fen);
        bus.i_w_en          = 1'b1;
        bus.i_w_data        = d;
        bus.i_fifo_enable   = fen;
        @(negedge clk);
        bus.i_w_en          = 1'b0;
        bus.i_fifo_enable   = 1'b1;
        if (fen && model_q.size() < D) model_q.push_back(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.o_tx, bus.o_busy, bus.o_count, bus.o_empty, bus.o_aempty, bus.o_full, bus.o_afull, bus.o_overflow}
            !== {1'b1, 1'b0, CW'(0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got tx/busy/count/e/ae/f/af/ovf=%b %b %0d %b %b %b %b %b",
                     bus.o_tx, bus.o_busy, bus.o_count, bus.o_empty, bus.o_aempty, bus.o_full,
                     bus.o_afull, bus.o_overflow);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.o_tx !== 1'b1 || bus.o_empty !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: tx=%b empty=%b busy=%b required 1 1 0", bus.o_tx, bus.o_empty, bus.o_busy);
        end
    endtask

    task automatic test_basic_frame();
        set_cfg(4, 2'b00, 1'b0, 1'b1);
        bus.i_tx_enable = 1'b1;
        model_q.delete();
        write_word(8'hA5, 1'b1);
        n_cmp++;
        if (bus.o_count !== CW'(1) || bus.o_empty !== 1'b0 || bus.o_tx !== 1'b1) begin
            n_err++;
            $display("FAIL basic_after_write: count=%0d empty=%b tx=%b required 1 0 1", bus.o_count, bus.o_empty, bus.o_tx);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.o_tx !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL basic_pop_latency: tx=%b busy=%b empty=%b required 0 1 1", bus.o_tx, bus.o_busy, bus.o_empty);
        end
        build_frame(8'hA5, 4, 2'b00, 1'b0, 1'b1);
        capture(exp_len, -1);
        n_cmp++;
        if (cap_tx !== exp_tx || cap_busy !== exp_busy) begin
            n_err++;
            $display("FAIL basic_frame: tx=%h busy=%h required tx=%h busy=%h", cap_tx, cap_busy, exp_tx, exp_busy);
        end
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_tx !== 1'b1) begin
            n_err++;
            $display("FAIL basic_end: busy=%b tx=%b required 0 1", bus.o_busy, bus.o_tx);
        end
    endtask

    task automatic test_parity_stop();
        logic [W-1:0] td[4];
        int           tdiv[4];
        logic [1:0]   tmode[4];
        logic         ttwo[4];
        logic         tlsb[4];
        logic         found;
        td   = '{8'h07, 8'h07, 8'h07, 8'h80};
        tdiv = '{2, 2, 2, 3};
        tmode = '{2'b01, 2'b10, 2'b10, 2'b00};
        ttwo = '{1'b0, 1'b0, 1'b1, 1'b0};
        tlsb = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.i_tx_enable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_cfg(tdiv[c], tmode[c], ttwo[c], tlsb[c]);
            write_word(td[c], 1'b1);
            void'(model_q.pop_front());
            wait_start(8, found);
            n_cmp++;
            if (!found) begin
                n_err++;
                $display("FAIL parity_stop_start case %0d: no start bit within 8 clk", c);
            end
            build_frame(td[c], tdiv[c], tmode[c], ttwo[c], tlsb[c]);
            capture(exp_len, -1);
            n_cmp++;
            if (cap_tx !== exp_tx || cap_busy !== exp_busy || bus.o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL parity_stop case %0d: tx=%h busy=%h end_busy=%b required tx=%h busy=%h end_busy=0",
                         c, cap_tx, cap_busy, bus.o_busy, exp_tx, exp_busy);
            end
        end
    endtask

    task automatic test_fill_overflow();
        logic         ovf_m;
        logic         found;
        logic [W-1:0] w;
        int           c;
        bus.i_tx_enable = 1'b0;
        set_cfg(1, 2'b00, 1'b0, 1'b1);
        model_q.delete();
        ovf_m = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) write_word(W'($urandom), 1'b0);
            else begin
                if (model_q.size() == D) ovf_m = 1'b1;
                write_word(W'($urandom), 1'b1);
            end
            c = model_q.size();
            n_cmp++;
            if (bus.o_count !== CW'(c) || bus.o_empty !== (c == 0) || bus.o_aempty !== (c <= int'(LVL)) ||
                bus.o_afull !== (c >= int'(D - LVL)) || bus.o_full !== (c == int'(D)) || bus.o_overflow !== ovf_m) begin
                n_err++;
                $display("FAIL fill step %0d: count=%0d e=%b ae=%b af=%b f=%b ovf=%b required count=%0d ovf=%b",
                         k, bus.o_count, bus.o_empty, bus.o_aempty, bus.o_afull, bus.o_full, bus.o_overflow, c, ovf_m);
            end
        end
        // Clear racing an overflowing write: the write wins.
        bus.i_clr_ovf = 1'b1;
        write_word(W'($urandom), 1'b1);
        bus.i_clr_ovf = 1'b0;
        n_cmp++;
        if (bus.o_overflow !== 1'b1 || bus.o_count !== CW'(D)) begin
            n_err++;
            $display("FAIL clr_vs_write: ovf=%b count=%0d required 1 %0d", bus.o_overflow, bus.o_count, D);
        end
        bus.i_clr_ovf = 1'b1;
        @(negedge clk);
        bus.i_clr_ovf = 1'b0;
        n_cmp++;
        if (bus.o_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ovf: ovf=%b required 0", bus.o_overflow);
        end
        // Write while full in the same cycle as the first pop: dropped, overflow set.
        bus.i_tx_enable = 1'b1;
        write_word(8'h3C, 1'b1);
        n_cmp++;
        if (bus.o_count !== CW'(D - 1) || bus.o_overflow !== 1'b1 || bus.o_tx !== 1'b0) begin
            n_err++;
            $display("FAIL full_write_with_pop: count=%0d ovf=%b tx=%b required %0d 1 0",
                     bus.o_count, bus.o_overflow, bus.o_tx, D - 1);
        end
        wait_start(2, found);
        for (int f = 0; f < int'(D); f++) begin
            w = model_q.pop_front();
            build_frame(w, 1, 2'b00, 1'b0, 1'b1);
            capture(exp_len, -1);
            n_cmp++;
            if (cap_tx !== exp_tx || cap_busy !== exp_busy) begin
                n_err++;
                $display("FAIL drain frame %0d: tx=%h busy=%h required tx=%h busy=%h", f, cap_tx, cap_busy, exp_tx, exp_busy);
            end
        end
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_tx !== 1'b1 || bus.o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL drain_end: busy=%b tx=%b empty=%b required 0 1 1", bus.o_busy, bus.o_tx, bus.o_empty);
        end
        bus.i_tx_enable = 1'b0;
        bus.i_clr_ovf   = 1'b1;
        @(negedge clk);
        bus.i_clr_ovf   = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic         found;
        logic [W-1:0] w;
        bus.i_tx_enable = 1'b0;
        set_cfg(1, 2'b00, 1'b0, 1'b1);
        model_q.delete();
        for (int k = 0; k < 3; k++) write_word(W'($urandom), 1'b1);
        bus.i_tx_enable = 1'b1;
        wait_start(4, found);
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL b2b_start: no start bit within 4 clk");
        end
        for (int f = 0; f < 3; f++) begin
            n_cmp++;
            if (bus.o_empty !== (f == 2)) begin
                n_err++;
                $display("FAIL b2b_empty frame %0d: empty=%b required %b", f, bus.o_empty, (f == 2));
            end
            w = model_q.pop_front();
            build_frame(w, 1, 2'b00, 1'b0, 1'b1);
            capture(exp_len, -1);
            n_cmp++;
            if (cap_tx !== exp_tx || cap_busy !== exp_busy) begin
                n_err++;
                $display("FAIL b2b frame %0d: tx=%h busy=%h required tx=%h busy=%h", f, cap_tx, cap_busy, exp_tx, exp_busy);
            end
        end
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_tx !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_end: busy=%b tx=%b required 0 1", bus.o_busy, bus.o_tx);
        end
        bus.i_tx_enable = 1'b0;
    endtask

    task automatic test_mid_frame();
        logic         found, saw_low;
        logic [W-1:0] w1, w2;
        bus.i_tx_enable = 1'b0;
        set_cfg(3, 2'b01, 1'b0, 1'b1);
        model_q.delete();
        w1 = W'($urandom);
        w2 = W'($urandom);
        write_word(w1, 1'b1);
        write_word(w2, 1'b1);
        bus.i_tx_enable = 1'b1;
        wait_start(4, found);
        build_frame(w1, 3, 2'b01, 1'b0, 1'b1);
        capture(exp_len, 3 * 4);
        n_cmp++;
        if (cap_tx !== exp_tx || cap_busy !== exp_busy) begin
            n_err++;
            $display("FAIL mid_frame_format: tx=%h busy=%h required tx=%h busy=%h", cap_tx, cap_busy, exp_tx, exp_busy);
        end
        saw_low = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0) saw_low = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (saw_low || bus.o_count !== CW'(1)) begin
            n_err++;
            $display("FAIL mid_frame_no_next: activity=%b count=%0d required 0 1", saw_low, bus.o_count);
        end
        // The new config (div 7, odd, two stop, MSB first) applies from the next pop.
        bus.i_tx_enable = 1'b1;
        wait_start(4, found);
        build_frame(w2, 7, 2'b10, 1'b1, 1'b0);
        capture(exp_len, -1);
        n_cmp++;
        if (cap_tx !== exp_tx || cap_busy !== exp_busy) begin
            n_err++;
            $display("FAIL mid_frame_new_cfg: tx=%h busy=%h required tx=%h busy=%h", cap_tx, cap_busy, exp_tx, exp_busy);
        end
        bus.i_tx_enable = 1'b0;
    endtask

    task automatic test_random();
        logic         found;
        logic [W-1:0] w;
        int           div, n;
        logic [1:0]   mode;
        logic         two, lsb;
        for (int it = 0; it < 8; it++) begin
            bus.i_tx_enable = 1'b0;
            div  = int'($urandom_range(0, 4));
            mode = 2'($urandom_range(0, 3));
            two  = 1'($urandom_range(0, 1));
            lsb  = 1'($urandom_range(0, 1));
            set_cfg(div, mode, two, lsb);
            model_q.delete();
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) write_word(W'($urandom), ($urandom_range(0, 3) != 0));
            n_cmp++;
            if (bus.o_count !== CW'(model_q.size())) begin
                n_err++;
                $display("FAIL rand_count it %0d: count=%0d required %0d", it, bus.o_count, model_q.size());
            end
            if (model_q.size() == 0) continue;
            bus.i_tx_enable = 1'b1;
            wait_start(6, found);
            n_cmp++;
            if (!found) begin
                n_err++;
                $display("FAIL rand_start it %0d: no start bit within 6 clk", it);
            end
            while (model_q.size() > 0) begin
                w = model_q.pop_front();
                build_frame(w, div, mode, two, lsb);
                capture(exp_len, -1);
                n_cmp++;
                if (cap_tx !== exp_tx || cap_busy !== exp_busy) begin
                    n_err++;
                    $display("FAIL rand_frame it %0d data %h: tx=%h busy=%h required tx=%h busy=%h",
                             it, w, cap_tx, cap_busy, exp_tx, exp_busy);
                end
            end
            n_cmp++;
            if (bus.o_busy !== 1'b0 || bus.o_empty !== 1'b1) begin
                n_err++;
                $display("FAIL rand_end it %0d: busy=%b empty=%b required 0 1", it, bus.o_busy, bus.o_empty);
            end
        end
        bus.i_tx_enable = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic found, bad;
        set_cfg(4, 2'b00, 1'b0, 1'b1);
        bus.i_tx_enable = 1'b1;
        model_q.delete();
        write_word(W'($urandom), 1'b1);
        write_word(W'($urandom), 1'b1);
        wait_start(4, found);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_tx, bus.o_busy, bus.o_count, bus.o_empty, bus.o_aempty, bus.o_overflow}
            !== {1'b1, 1'b0, CW'(0), 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_async: tx/busy/count/e/ae/ovf=%b %b %0d %b %b %b required 1 0 0 1 1 0",
                     bus.o_tx, bus.o_busy, bus.o_count, bus.o_empty, bus.o_aempty, bus.o_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_empty !== 1'b1) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL reset_no_resume: tx=%b busy=%b empty=%b required 1 0 1", bus.o_tx, bus.o_busy, bus.o_empty);
        end
        bus.i_tx_enable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n             = 1'b0;
        bus.i_fifo_enable = 1'b1;
        bus.i_tx_enable   = 1'b0;
        bus.i_w_en        = 1'b0;
        bus.i_w_data      = '0;
        bus.i_clr_ovf     = 1'b0;
        set_cfg(4, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_parity_stop();
        test_fill_overflow();
        test_back_to_back();
        test_mid_frame();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx_cfg.md
Name: fifo_uart_tx_cfg

Overview:
Buffered, runtime-configurable UART transmitter: a write-side FIFO feeding a serialiser with a programmable baud divisor, parity mode, stop-bit count and bit order. It is the next generation of our FIFO-fronted UART TX. It adds occupancy reporting, sticky overflow detection, gapless back-to-back frames and per-frame configuration latching. It sits between register/stream logic and the board TX pin.

Parameters:
WIDTH, 8, data bits per frame (5..9)
DEPTH, 128, FIFO depth in words (power of 2, >=4)
LEVEL, 16, almost-full/almost-empty threshold (1..DEPTH/2)
DIV_WIDTH, 16, width of runtime divisor input
CW, $clog2(DEPTH)+1, occupancy count width (derived, localparam)

Ports:
clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_fifo_enable  input  1  gates writes into the FIFO
i_tx_enable  input  1  permits starting new frames
i_w_en  input  1  write strobe
i_w_data  input  WIDTH  write data
i_divisor  input  DIV_WIDTH  clocks per bit; 0 treated as 1
i_parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
i_two_stop  input  1  1 = two stop bits
i_lsb_first  input  1  1 = LSB sent first
i_clr_ovf  input  1  clears o_overflow
o_tx  output  1  serial line, idle high, registered
o_busy  output  1  frame in progress
o_full  output  1  count == DEPTH
o_afull  output  1  count >= DEPTH-LEVEL
o_empty  output  1  count == 0
o_aempty  output  1  count <= LEVEL
o_count  output  CW  words stored
o_overflow  output  1  sticky: write attempted while full

Behaviour:
- Reset (async assert, sync release): o_tx=1, o_busy=0, o_count=0, o_empty=1, o_aempty=1, o_full=0, o_afull=0, o_overflow=0. FIFO pointers are cleared and FSM enters IDLE. Reset mid-frame aborts the frame immediately; no partial frame resumes.
- Write accepted when i_w_en & i_fifo_enable & !o_full, using registered full. Write with o_full=1 is dropped and sets o_overflow, even if a pop occurs in the same cycle. Write with i_fifo_enable=0 is ignored and does not set overflow.
- i_clr_ovf clears o_overflow next cycle. A simultaneous overflowing write wins: o_overflow stays 1.
- Simultaneous accepted write and pop: count unchanged; data ordering preserved. Pointers wrap modulo DEPTH.
- Flags and o_count are registered and update the cycle after the write/pop.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if i_tx_enable & !o_empty, pop the head word in this cycle (N). Latch data, divisor (0->1), parity mode, stop count and bit order. Go to START; o_tx=0 and o_busy=1 from cycle N+1.
- Each bit is held exactly divisor clocks, counted by a DIV_WIDTH bit-timer.
- DATA: WIDTH bits, ordered per latched i_lsb_first.
- PARITY: present only if mode 01/10. Even: bit = XOR of data. Odd: bit = ~XOR.
- STOP: 1 or 2 bit periods high.
- On the last cycle of STOP: if i_tx_enable & !o_empty, pop and enter START directly with no idle gap. Otherwise return to IDLE with o_busy=0 next cycle.
- Config inputs changing mid-frame have no effect until the next pop.
- i_tx_enable deasserting mid-frame: the current frame completes and no further pops occur.
- Frame length = divisor * (1 + WIDTH + P + S) clocks, where P is 0/1 and S is 1/2.

Test Plan:
- Reset check: assert i_reset_n=0 mid-run -> o_tx=1 asynchronously, o_count=0, o_empty=1, o_aempty=1, o_busy=0, o_overflow=0. After release, o_tx stays 1 with FIFO empty.
- Basic frame: WIDTH=8, divisor=4, no parity, 1 stop, LSB first; write 0xA5 -> o_tx low 4 clk, then 1,0,1,0,0,1,0,1 each 4 clk, then high 4 clk. o_busy high exactly 40 clk beginning the cycle after the pop.
- Parity/stop: 0x07, even parity -> parity bit 1; odd -> 0. With i_two_stop=1 and divisor=2, frame = 24 clk. MSB-first 0x80 -> first data bit 1.
- Fill/overflow: DEPTH=8, LEVEL=2, tx disabled. After 2 writes o_aempty=1, after 3 writes 0. After 6 writes o_afull=1, after 8 writes o_full=1. 9th write -> o_count stays 8, o_overflow=1. Pulse i_clr_ovf -> 0.
- Back-to-back: preload 3 words, enable tx, divisor=1 -> start bit of word 2 in the cycle after the last stop of word 1, no gap. o_empty=1 the cycle after the third pop. o_busy is continuous for 30 clk.
- Mid-frame changes: change i_divisor and i_parity_mode and drop i_tx_enable during DATA -> current frame timing and format unchanged, and no next frame starts.
